// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns a pipeline load/store request into
// data-memory bus cycles, holds the bus for WAIT_CYCLES extra cycles, and
// returns the sign/zero-extended load result. Misaligned requests are rejected
// with a one-cycle pulse and never reach the memory.
//
// Handshake: the pipeline presents req_i with op_i/addr_i/wdata_i. While
// stall_o=1 it must hold (or re-present) the request. The request is taken
// on the edge where the FSM is IDLE and req_i carries a valid, aligned op.
// Completion is signalled by a one-cycle done_o, with rdata_o valid during it.
// Requests seen outside IDLE are ignored.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_ADDR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [3:0]            op_i,
  input  logic [MEM_ADDR_W-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [31:0]           rdata_o,
  output logic                  misalign_o,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [31:0]           mem_data_o,
  output logic [3:0]            mem_byte_slct_o,
  input  logic [31:0]           mem_data_i,
  output logic [1:0]            dbg_state_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic [3:0]              op_q;
  logic [MEM_ADDR_W-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;

  logic                    op_valid, misalign, req_ok, req_bad;
  logic [31:0]             wdata_placed;
  logic                    is_store;
  logic [3:0]              lanes;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [31:0]             load_result;

  // Decode the incoming request: validity, alignment and store-data placement.
  always_comb begin
    op_valid = (op_i >= OP_LB) && (op_i <= OP_SW);
    misalign = (((op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH)) && addr_i[0]) ||
               (((op_i == OP_LW) || (op_i == OP_SW)) && (addr_i[1:0] != 2'b00));
    req_ok   = req_i && op_valid && !misalign;
    req_bad  = req_i && op_valid && misalign;
    case (op_i)
      OP_SB:   wdata_placed = {4{wdata_i[7:0]}};
      OP_SH:   wdata_placed = {2{wdata_i[15:0]}};
      OP_SW:   wdata_placed = wdata_i;
      default: wdata_placed = 32'd0;
    endcase
  end

  // Byte lanes and load extension from the latched op and offset (big-endian).
  always_comb begin
    is_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
    case (op_q)
      OP_LB, OP_LBU, OP_SB: lanes = 4'b1000 >> addr_q[1:0];
      OP_LH, OP_LHU, OP_SH: lanes = addr_q[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         lanes = 4'b1111;
      default:              lanes = 4'b0000;
    endcase
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_data_i[31:24];
      2'd1:    byte_sel = mem_data_i[23:16];
      2'd2:    byte_sel = mem_data_i[15:8];
      default: byte_sel = mem_data_i[7:0];
    endcase
    half_sel = addr_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    case (op_q)
      OP_LB:   load_result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_result = {24'd0, byte_sel};
      OP_LH:   load_result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_result = {16'd0, half_sel};
      OP_LW:   load_result = mem_data_i;
      default: load_result = 32'd0;
    endcase
  end

  // State register; reset drops the bus immediately since outputs decode state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Request latch, wait counter and load-result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else if (state_q == S_IDLE) begin
      if (req_ok) begin
        op_q    <= op_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_placed;
        cnt_q   <= 4'(WAIT_CYCLES);
      end
    end else if (state_q == S_ACCESS) begin
      if (cnt_q == 4'd0) rdata_q <= load_result;
      else               cnt_q   <= cnt_q - 4'd1;
    end
  end

  // Next-state logic and all bus/pipeline outputs.
  always_comb begin
    state_d         = state_q;
    stall_o         = 1'b0;
    done_o          = 1'b0;
    misalign_o      = 1'b0;
    mem_ce_o        = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_data_o      = 32'd0;
    mem_byte_slct_o = 4'd0;
    case (state_q)
      S_IDLE: begin
        stall_o = req_ok;
        if (req_ok)       state_d = S_ACCESS;
        else if (req_bad) state_d = S_ERR;
      end
      S_ACCESS: begin
        stall_o         = 1'b1;
        mem_ce_o        = 1'b1;
        mem_we_o        = is_store;
        mem_addr_o      = {addr_q[MEM_ADDR_W-1:2], 2'b00};
        mem_data_o      = wdata_q;
        mem_byte_slct_o = lanes;
        if (cnt_q == 4'd0) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        misalign_o = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  assign rdata_o     = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with WAIT_CYCLES=1 and a small
// byte-lane-writable memory model on the bus.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall, done, misalign, ce, we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  byte_slct;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  mem_access_ctrl #(.WAIT_CYCLES(1), .MEM_ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_i(req), .op_i(op), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall), .done_o(done), .rdata_o(rdata), .misalign_o(misalign),
    .mem_ce_o(ce), .mem_we_o(we), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_byte_slct_o(byte_slct), .mem_data_i(mem_rdata), .dbg_state_o(dbg_state)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Memory model: combinational read, byte-lane write on the clock edge
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (ce && we) begin
      if (byte_slct[3]) mem[mem_addr[7:2]][31:24] <= mem_wdata[31:24];
      if (byte_slct[2]) mem[mem_addr[7:2]][23:16] <= mem_wdata[23:16];
      if (byte_slct[1]) mem[mem_addr[7:2]][15:8]  <= mem_wdata[15:8];
      if (byte_slct[0]) mem[mem_addr[7:2]][7:0]   <= mem_wdata[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full access with WAIT_CYCLES=1: request cycle, two ACCESS cycles, DONE.
  task automatic do_access(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] d, input logic exp_we, input logic [3:0] exp_lanes,
                           input logic [31:0] exp_data, input logic [31:0] exp_rdata);
    req = 1'b1; op = o; addr = a; wdata = d;
    #1;
    check({tag, "_req_stall"}, stall, 1);
    step();
    // inputs change after latching; the bus must keep the latched values
    req = 1'b0; op = 4'd0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
    for (int k = 0; k < 2; k++) begin
      check({tag, "_ce"}, ce, 1);
      check({tag, "_we"}, we, exp_we);
      check({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
      check({tag, "_lanes"}, byte_slct, exp_lanes);
      if (exp_we) check({tag, "_wdata"}, mem_wdata, exp_data);
      check({tag, "_acc_stall"}, stall, 1);
      check({tag, "_acc_done"}, done, 0);
      step();
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_done_ce"}, ce, 0);
    check({tag, "_done_stall"}, stall, 0);
    check({tag, "_done_state"}, dbg_state, 2);
    step();
    check({tag, "_post_done"}, done, 0);
    check({tag, "_post_state"}, dbg_state, 0);
  endtask

  task automatic do_misalign(input string tag, input logic [3:0] o, input logic [31:0] a);
    req = 1'b1; op = o; addr = a; wdata = 32'h0;
    #1;
    check({tag, "_req_stall"}, stall, 0);
    step();
    req = 1'b0; op = 4'd0;
    check({tag, "_pulse"}, misalign, 1);
    check({tag, "_err_state"}, dbg_state, 3);
    check({tag, "_ce"}, ce, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_stall"}, stall, 0);
    step();
    check({tag, "_pulse_end"}, misalign, 0);
    check({tag, "_idle"}, dbg_state, 0);
  endtask

  initial begin
    logic [7:0] stall_pat;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    rst = 1'b0; req = 1'b0; op = 4'd0; addr = 32'd0; wdata = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce", ce, 0);
    check("rst_we", we, 0);
    check("rst_done", done, 0);
    check("rst_misalign", misalign, 0);
    check("rst_stall", stall, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_lanes", byte_slct, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Word, byte and half stores and loads, big-endian lanes
    do_access("sw10",  4'd8, 32'h10, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0);
    do_access("lw10",  4'd5, 32'h10, 32'h0,        1'b0, 4'b1111, 32'h0,        32'hDEADBEEF);
    do_access("lb12",  4'd1, 32'h12, 32'h0,        1'b0, 4'b0010, 32'h0,        32'hFFFFFFBE);
    do_access("lbu13", 4'd2, 32'h13, 32'h0,        1'b0, 4'b0001, 32'h0,        32'h000000EF);
    do_access("lh10",  4'd3, 32'h10, 32'h0,        1'b0, 4'b1100, 32'h0,        32'hFFFFDEAD);
    do_access("sb21",  4'd6, 32'h21, 32'h000000A5, 1'b1, 4'b0100, 32'hA5A5A5A5, 32'h0);
    do_access("lb21",  4'd1, 32'h21, 32'h0,        1'b0, 4'b0100, 32'h0,        32'hFFFFFFA5);
    do_access("lbu21", 4'd2, 32'h21, 32'h0,        1'b0, 4'b0100, 32'h0,        32'h000000A5);
    do_access("sh32",  4'd7, 32'h32, 32'h00008001, 1'b1, 4'b0011, 32'h80018001, 32'h0);
    do_access("lh32",  4'd3, 32'h32, 32'h0,        1'b0, 4'b0011, 32'h0,        32'hFFFF8001);
    do_access("lhu30", 4'd4, 32'h30, 32'h0,        1'b0, 4'b1100, 32'h0,        32'h00000000);

    // Misaligned requests are rejected without bus activity
    do_misalign("mis_lw13",  4'd5, 32'h13);
    do_misalign("mis_lhu33", 4'd4, 32'h33);

    // Invalid op is ignored
    req = 1'b1; op = 4'd12; addr = 32'h10;
    #1;
    check("nop_stall", stall, 0);
    step();
    check("nop_state", dbg_state, 0);
    check("nop_ce", ce, 0);
    req = 1'b0; op = 4'd0;

    // Reset during the second ACCESS cycle of a store
    req = 1'b1; op = 4'd8; addr = 32'h40; wdata = 32'h12345678;
    step();
    req = 1'b0; op = 4'd0;
    step();
    check("rstmid_ce_before", ce, 1);
    rst = 1'b0;
    #1;
    check("rstmid_ce", ce, 0);
    check("rstmid_we", we, 0);
    check("rstmid_state", dbg_state, 0);
    #3;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rstmid_no_done", done, 0);
      check("rstmid_idle_ce", ce, 0);
      check("rstmid_idle_stall", stall, 0);
      check("rstmid_idle_state", dbg_state, 0);
    end

    // Back-to-back loads with the request held high
    req = 1'b1; op = 4'd5; addr = 32'h10;
    stall_pat = 8'd0;
    #1;
    for (int k = 0; k < 8; k++) begin
      stall_pat = {stall_pat[6:0], stall};
      if (k == 3 || k == 7) begin
        check("b2b_done", done, 1);
        check("b2b_rdata", rdata, 32'hDEADBEEF);
      end
      step();
    end
    check("b2b_stall_pattern", {24'd0, stall_pat}, 32'h000000EE);
    req = 1'b0; op = 4'd0;
    repeat (4) step();
    check("final_idle", dbg_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
